// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcodes, operand-select encodings and datapath width
package alu_pkg;

   localparam int XLEN = 32;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'b0000,
      ALU_SUB  = 4'b0001,
      ALU_AND  = 4'b0010,
      ALU_OR   = 4'b0011,
      ALU_XOR  = 4'b0100,
      ALU_SLT  = 4'b0101,
      ALU_SLTU = 4'b0110,
      ALU_SLL  = 4'b0111,
      ALU_SRL  = 4'b1000,
      ALU_SRA  = 4'b1001
   } alu_op_e;

   localparam logic SRC_A_RS1 = 1'b0;
   localparam logic SRC_A_PC  = 1'b1;
   localparam logic SRC_B_RS2 = 1'b0;
   localparam logic SRC_B_IMM = 1'b1;

endpackage

// File: rtl/operand_fwd.sv
// rtl/operand_fwd.sv - priority forward mux: EX/MEM result, then writeback, then stored value
module operand_fwd #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic [REG_AW-1:0] addr_i,
   input  logic [XLEN-1:0]   stored_i,
   input  logic              exm_we_i,
   input  logic [REG_AW-1:0] exm_rd_i,
   input  logic [XLEN-1:0]   exm_data_i,
   input  logic              wb_we_i,
   input  logic [REG_AW-1:0] wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   output logic [XLEN-1:0]   value_o
);

   logic exm_hit;
   logic wb_hit;

   // x0 is never a forward target, so it always reads the stored zero
   assign exm_hit = exm_we_i && (exm_rd_i == addr_i) && (addr_i != '0);
   assign wb_hit  = wb_we_i  && (wb_rd_i  == addr_i) && (addr_i != '0);

   always_comb begin
      value_o = stored_i;
      if (exm_hit) begin
         value_o = exm_data_i;
      end else if (wb_hit) begin
         value_o = wb_data_i;
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - single-entry ALU issue register with operand snoop and forwarding
// EX/MEM forwarding is compiled in only when ALU_ISSUE_FWD_EN is defined.
module alu_issue_stage #(
   parameter int XLEN   = alu_pkg::XLEN,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_pc,
   input  logic [XLEN-1:0]   in_imm,
   input  logic [XLEN-1:0]   in_rs1_data,
   input  logic [XLEN-1:0]   in_rs2_data,
   input  logic [REG_AW-1:0] in_rs1,
   input  logic [REG_AW-1:0] in_rs2,
   input  logic [REG_AW-1:0] in_rd,
   input  logic              in_src_a_sel,
   input  logic              in_src_b_sel,
   input  logic [3:0]        in_alu_control,
   input  logic              in_reg_write,
   input  logic              flush,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [XLEN-1:0]   exm_result,
   input  logic              wb_we,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   alu_a,
   output logic [XLEN-1:0]   alu_b,
   output logic [3:0]        alu_control,
   output logic [REG_AW-1:0] out_rd,
   output logic              out_reg_write,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_store_data
);

   import alu_pkg::*;

   logic              valid_q,       valid_d;
   logic [XLEN-1:0]   pc_q,          pc_d;
   logic [XLEN-1:0]   imm_q,         imm_d;
   logic [XLEN-1:0]   rs1_val_q,     rs1_val_d;
   logic [XLEN-1:0]   rs2_val_q,     rs2_val_d;
   logic [REG_AW-1:0] rs1_q,         rs1_d;
   logic [REG_AW-1:0] rs2_q,         rs2_d;
   logic [REG_AW-1:0] rd_q,          rd_d;
   logic              src_a_sel_q,   src_a_sel_d;
   logic              src_b_sel_q,   src_b_sel_d;
   logic [3:0]        alu_control_q, alu_control_d;
   logic              reg_write_q,   reg_write_d;

   logic accept;
   logic drain;
   logic cap1_hit, cap2_hit;
   logic snoop1_hit, snoop2_hit;
   logic exm_we_eff;
   logic [XLEN-1:0] fwd1, fwd2;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign drain    = valid_q && out_ready;

   assign cap1_hit   = wb_we && (wb_rd == in_rs1) && (in_rs1 != '0);
   assign cap2_hit   = wb_we && (wb_rd == in_rs2) && (in_rs2 != '0);
   assign snoop1_hit = wb_we && (wb_rd == rs1_q)  && (rs1_q  != '0);
   assign snoop2_hit = wb_we && (wb_rd == rs2_q)  && (rs2_q  != '0);

   always_comb begin
      valid_d       = valid_q;
      pc_d          = pc_q;
      imm_d         = imm_q;
      rs1_val_d     = rs1_val_q;
      rs2_val_d     = rs2_val_q;
      rs1_d         = rs1_q;
      rs2_d         = rs2_q;
      rd_d          = rd_q;
      src_a_sel_d   = src_a_sel_q;
      src_b_sel_d   = src_b_sel_q;
      alu_control_d = alu_control_q;
      reg_write_d   = reg_write_q;

      if (accept) begin
         pc_d          = in_pc;
         imm_d         = in_imm;
         rs1_val_d     = cap1_hit ? wb_data : in_rs1_data;
         rs2_val_d     = cap2_hit ? wb_data : in_rs2_data;
         rs1_d         = in_rs1;
         rs2_d         = in_rs2;
         rd_d          = in_rd;
         src_a_sel_d   = in_src_a_sel;
         src_b_sel_d   = in_src_b_sel;
         alu_control_d = in_alu_control;
         reg_write_d   = in_reg_write;
      end else if (valid_q && !out_ready) begin
         // held entry keeps its operands fresh against regfile writes
         if (snoop1_hit) rs1_val_d = wb_data;
         if (snoop2_hit) rs2_val_d = wb_data;
      end

      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d = 1'b1;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q       <= 1'b0;
         pc_q          <= '0;
         imm_q         <= '0;
         rs1_val_q     <= '0;
         rs2_val_q     <= '0;
         rs1_q         <= '0;
         rs2_q         <= '0;
         rd_q          <= '0;
         src_a_sel_q   <= 1'b0;
         src_b_sel_q   <= 1'b0;
         alu_control_q <= '0;
         reg_write_q   <= 1'b0;
      end else begin
         valid_q       <= valid_d;
         pc_q          <= pc_d;
         imm_q         <= imm_d;
         rs1_val_q     <= rs1_val_d;
         rs2_val_q     <= rs2_val_d;
         rs1_q         <= rs1_d;
         rs2_q         <= rs2_d;
         rd_q          <= rd_d;
         src_a_sel_q   <= src_a_sel_d;
         src_b_sel_q   <= src_b_sel_d;
         alu_control_q <= alu_control_d;
         reg_write_q   <= reg_write_d;
      end
   end

`ifdef ALU_ISSUE_FWD_EN
   assign exm_we_eff = exm_reg_write;
`else
   // without the EX/MEM path the hazard unit adds a stall instead
   logic unused_exm_we;
   assign unused_exm_we = exm_reg_write;
   assign exm_we_eff    = 1'b0;
`endif

   operand_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd1 (
      .addr_i     (rs1_q),
      .stored_i   (rs1_val_q),
      .exm_we_i   (exm_we_eff),
      .exm_rd_i   (exm_rd),
      .exm_data_i (exm_result),
      .wb_we_i    (wb_we),
      .wb_rd_i    (wb_rd),
      .wb_data_i  (wb_data),
      .value_o    (fwd1)
   );

   operand_fwd #(.XLEN(XLEN), .REG_AW(REG_AW)) u_fwd2 (
      .addr_i     (rs2_q),
      .stored_i   (rs2_val_q),
      .exm_we_i   (exm_we_eff),
      .exm_rd_i   (exm_rd),
      .exm_data_i (exm_result),
      .wb_we_i    (wb_we),
      .wb_rd_i    (wb_rd),
      .wb_data_i  (wb_data),
      .value_o    (fwd2)
   );

   assign out_valid      = valid_q;
   assign alu_a          = (src_a_sel_q == SRC_A_PC)  ? pc_q  : fwd1;
   assign alu_b          = (src_b_sel_q == SRC_B_IMM) ? imm_q : fwd2;
   assign out_store_data = fwd2;
   assign alu_control    = alu_control_q;
   assign out_rd         = rd_q;
   assign out_reg_write  = reg_write_q;
   assign out_pc         = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - scoreboard bench for alu_issue_stage
module tb_alu_issue_stage;

   localparam logic [31:0] EXP_FWD =
`ifdef ALU_ISSUE_FWD_EN
      32'h20;
`else
      32'h10;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready;
   logic [31:0] in_pc, in_imm, in_rs1_data, in_rs2_data;
   logic [4:0]  in_rs1, in_rs2, in_rd;
   logic        in_src_a_sel, in_src_b_sel;
   logic [3:0]  in_alu_control;
   logic        in_reg_write;
   logic        flush;
   logic        exm_reg_write;
   logic [4:0]  exm_rd;
   logic [31:0] exm_result;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid, out_ready;
   logic [31:0] alu_a, alu_b, out_pc, out_store_data;
   logic [3:0]  alu_control;
   logic [4:0]  out_rd;
   logic        out_reg_write;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] store;
      logic [31:0] pc;
      logic [3:0]  ctrl;
      logic [4:0]  rd;
      logic        rw;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_pc          (in_pc),
      .in_imm         (in_imm),
      .in_rs1_data    (in_rs1_data),
      .in_rs2_data    (in_rs2_data),
      .in_rs1         (in_rs1),
      .in_rs2         (in_rs2),
      .in_rd          (in_rd),
      .in_src_a_sel   (in_src_a_sel),
      .in_src_b_sel   (in_src_b_sel),
      .in_alu_control (in_alu_control),
      .in_reg_write   (in_reg_write),
      .flush          (flush),
      .exm_reg_write  (exm_reg_write),
      .exm_rd         (exm_rd),
      .exm_result     (exm_result),
      .wb_we          (wb_we),
      .wb_rd          (wb_rd),
      .wb_data        (wb_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .alu_a          (alu_a),
      .alu_b          (alu_b),
      .alu_control    (alu_control),
      .out_rd         (out_rd),
      .out_reg_write  (out_reg_write),
      .out_pc         (out_pc),
      .out_store_data (out_store_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic idle();
      in_valid      = 1'b0;
      flush         = 1'b0;
      exm_reg_write = 1'b0;
      exm_rd        = '0;
      exm_result    = '0;
      wb_we         = 1'b0;
      wb_rd         = '0;
      wb_data       = '0;
   endtask

   task automatic drive(input logic [31:0] pc, input logic [31:0] imm,
                        input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] r2, input logic [31:0] d2,
                        input logic [4:0] rd, input logic sa, input logic sbs,
                        input logic [3:0] ctrl, input logic rw);
      in_valid       = 1'b1;
      in_pc          = pc;
      in_imm         = imm;
      in_rs1         = r1;
      in_rs1_data    = d1;
      in_rs2         = r2;
      in_rs2_data    = d2;
      in_rd          = rd;
      in_src_a_sel   = sa;
      in_src_b_sel   = sbs;
      in_alu_control = ctrl;
      in_reg_write   = rw;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                       input logic [31:0] pc, input logic [3:0] ctrl, input logic [4:0] rd,
                       input logic rw);
      exp_t e;
      e.a = a; e.b = b; e.store = st; e.pc = pc; e.ctrl = ctrl; e.rd = rd; e.rw = rw;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // monitor: pops on every output handshake, and polices stall stability
   logic       stall_prev = 1'b0;
   logic [3:0] prev_ctrl;
   logic [4:0] prev_rd;

   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            stall_prev = 1'b0;
         end else begin
            if (stall_prev) begin
               chk("stall_valid", 32'(out_valid), 32'd1);
               chk("stall_ctrl", 32'(alu_control), 32'(prev_ctrl));
               chk("stall_rd", 32'(out_rd), 32'(prev_rd));
            end
            if (out_valid && out_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_output pc=%h t=%0t", out_pc, $time);
               end else begin
                  exp_t e;
                  e = exp_q.pop_front();
                  chk("alu_a", alu_a, e.a);
                  chk("alu_b", alu_b, e.b);
                  chk("store_data", out_store_data, e.store);
                  chk("out_pc", out_pc, e.pc);
                  chk("alu_control", 32'(alu_control), 32'(e.ctrl));
                  chk("out_rd", 32'(out_rd), 32'(e.rd));
                  chk("reg_write", 32'(out_reg_write), 32'(e.rw));
               end
            end
            stall_prev = out_valid && !out_ready && !flush;
            prev_ctrl  = alu_control;
            prev_rd    = out_rd;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      out_ready = 1'b0;
      idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 0);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // reset state
      @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_alu_control", 32'(alu_control), 32'd0);
      chk("rst_alu_a", alu_a, 32'd0);
      chk("rst_alu_b", alu_b, 32'd0);

      // basic ADD
      step();
      out_ready = 1'b1;
      drive(32'h40, 0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd5, 0, 0, 4'b0000, 1);
      push(32'd5, 32'd7, 32'd7, 32'h40, 4'b0000, 5'd5, 1);
      step(); idle();
      step();

      // EX/MEM forward beats writeback
      out_ready = 1'b0;
      drive(32'h44, 0, 5'd3, 32'd5, 5'd4, 32'd7, 5'd9, 0, 0, 4'b0001, 1);
      step(); idle();
      exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'h20;
      wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h10;
      push(EXP_FWD, 32'd7, 32'd7, 32'h44, 4'b0001, 5'd9, 1);
      out_ready = 1'b1;
      step(); idle();

      // stall with writeback snoop
      out_ready = 1'b0;
      drive(32'h48, 0, 5'd1, 32'hF0, 5'd4, 32'd7, 5'd6, 0, 0, 4'b0010, 1);
      step(); idle();
      wb_we = 1'b1; wb_rd = 5'd4; wb_data = 32'h99;
      @(negedge clk);
      chk("stall1_alu_b", alu_b, 32'h99);
      chk("stall1_in_ready", 32'(in_ready), 32'd0);
      for (int c = 2; c <= 3; c++) begin
         step(); idle();
         @(negedge clk);
         chk("stall_alu_b", alu_b, 32'h99);
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         chk("stall_out_valid", 32'(out_valid), 32'd1);
      end
      step();
      push(32'hF0, 32'h99, 32'h99, 32'h48, 4'b0010, 5'd6, 1);
      out_ready = 1'b1;
      step();

      // x0 never forwards
      out_ready = 1'b0;
      drive(32'h4C, 0, 5'd0, 32'd0, 5'd2, 32'd3, 5'd7, 0, 0, 4'b0011, 1);
      step(); idle();
      exm_reg_write = 1'b1; exm_rd = 5'd0; exm_result = 32'hFF;
      wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'hEE;
      push(32'd0, 32'd3, 32'd3, 32'h4C, 4'b0011, 5'd7, 1);
      out_ready = 1'b1;
      step(); idle();

      // pc / imm selects, store data is forwarded rs2
      drive(32'h100, 32'hFFFF_FFFC, 5'd1, 32'd9, 5'd4, 32'h55, 5'd8, 1, 1, 4'b0101, 1);
      push(32'h100, 32'hFFFF_FFFC, 32'h55, 32'h100, 4'b0101, 5'd8, 1);
      step(); idle();
      step();

      // capture from writeback at accept, reserved opcode, no reg write
      drive(32'h104, 0, 5'd5, 32'h11, 5'd6, 32'h22, 5'd0, 0, 0, 4'b1111, 0);
      wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h77;
      push(32'h77, 32'h22, 32'h22, 32'h104, 4'b1111, 5'd0, 0);
      step(); idle();
      step();

      // back-to-back, one per cycle
      for (int i = 0; i < 3; i++) begin
         drive(32'h200 + 32'(i * 4), 0, 5'd1, 32'd10 + 32'(i), 5'd2, 32'd20 + 32'(i),
               5'(i + 1), 0, 0, 4'(4 + i * 3), 1);
         push(32'd10 + 32'(i), 32'd20 + 32'(i), 32'd20 + 32'(i), 32'h200 + 32'(i * 4),
              4'(4 + i * 3), 5'(i + 1), 1);
         @(negedge clk);
         chk("b2b_in_ready", 32'(in_ready), 32'd1);
         step();
      end
      idle();
      step();

      // flush beats a simultaneous accept
      flush = 1'b1;
      drive(32'h300, 0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 0, 0, 4'b0000, 1);
      step(); idle();
      @(negedge clk);
      chk("flush_accept_valid", 32'(out_valid), 32'd0);
      step();

      // flush kills a stalled entry, writeback in the same cycle
      out_ready = 1'b0;
      drive(32'h304, 0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 0, 0, 4'b0000, 1);
      step(); idle();
      flush = 1'b1; wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h5;
      step(); idle();
      @(negedge clk);
      chk("flush_held_valid", 32'(out_valid), 32'd0);
      step();

      // reset during a stall loses the entry
      drive(32'h400, 0, 5'd1, 32'd1, 5'd2, 32'd2, 5'd3, 0, 0, 4'b0000, 1);
      step(); idle();
      @(negedge clk);
      chk("pre_reset_valid", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("async_reset_valid", 32'(out_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_reset_valid", 32'(out_valid), 32'd0);
      end

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
